// File: rtl/ber_meter.sv
// ----------------------------------------------------------------------------
// ber_meter
//
// Bit-error-rate meter for the PRBS receive chain. The sliced receive bit is
// compared against a delayed copy of the local PRBS reference. In SEARCH the
// meter sweeps reference delays 0..NDELAY-1, accumulating WINDOW accepted
// strobes per candidate. It keeps the candidate with the fewest errors and
// locks to it. It locks early on any error-free window.
//
// In LOCK it keeps cumulative saturating bit/error counts. It also keeps
// checking each WINDOW of strobes, and it drops back to SEARCH when a window
// holds more than LOL_THRESH errors.
//
// Ports
//   clock        system clock
//   i_reset      asynchronous, active-high reset
//   i_enable     global enable; when low only reset and clear act
//   i_valid      symbol strobe (accepted when i_valid & i_enable & ~i_clear)
//   i_ref        PRBS reference bit
//   i_rx         sliced receive bit
//   i_clear      synchronous restart of search and counters
//   o_locked     high while in LOCK
//   o_delay      selected reference delay
//   o_min_err    error count of the best window of the last search
//   o_bit_count  bits counted while locked (saturating)
//   o_err_count  errors counted while locked (frozen with the bit count)
//   o_lol        one-cycle pulse on loss of lock
// ----------------------------------------------------------------------------
module ber_meter #(
    parameter int NDELAY     = 512,
    parameter int NB_DLY     = 9,
    parameter int WINDOW     = 511,
    parameter int NB_WIN     = 9,
    parameter int LOL_THRESH = 127,
    parameter int NB_COUNT   = 64
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_valid,
    input  logic                i_ref,
    input  logic                i_rx,
    input  logic                i_clear,
    output logic                o_locked,
    output logic [NB_DLY-1:0]   o_delay,
    output logic [NB_WIN-1:0]   o_min_err,
    output logic [NB_COUNT-1:0] o_bit_count,
    output logic [NB_COUNT-1:0] o_err_count,
    output logic                o_lol
);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCK   = 1'b1
    } state_t;

    localparam logic [NB_DLY-1:0] LAST_CAND = NB_DLY'(NDELAY - 1);
    localparam logic [NB_WIN-1:0] LAST_WIN  = NB_WIN'(WINDOW - 1);
    // One bit wider than the accumulator so a threshold above the
    // accumulator range is not silently truncated.
    localparam logic [NB_WIN:0]   LOL_LIM   = (NB_WIN + 1)'(LOL_THRESH);

    // Counters freeze once the bit count is all-ones. The error count can
    // never exceed the bit count, so one test covers both counters.
    function automatic logic cnt_full(input logic [NB_COUNT-1:0] cnt);
        return &cnt;
    endfunction

    function automatic logic [NB_COUNT-1:0] cnt_step(input logic [NB_COUNT-1:0] cnt,
                                                     input logic              inc);
        return cnt + NB_COUNT'(inc);
    endfunction

    state_t                state_q,    state_d;
    logic [NDELAY-2:0]     sr_q,       sr_d;
    logic [NB_DLY-1:0]     cand_q,     cand_d;
    logic [NB_WIN-1:0]     win_acc_q,  win_acc_d;
    logic [NB_WIN-1:0]     win_cnt_q,  win_cnt_d;
    logic [NB_WIN-1:0]     best_err_q, best_err_d;
    logic [NB_DLY-1:0]     best_dly_q, best_dly_d;
    logic [NB_DLY-1:0]     delay_q,    delay_d;
    logic [NB_WIN-1:0]     min_err_q,  min_err_d;
    logic [NB_COUNT-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [NB_COUNT-1:0]   err_cnt_q,  err_cnt_d;
    logic                  lol_q,      lol_d;

    logic                  accept;
    logic [NDELAY-1:0]     taps;
    logic [NB_DLY-1:0]     sel_dly;
    logic                  err_bit;
    logic [NB_WIN-1:0]     total;
    logic                  win_end;
    logic                  better;
    logic [NB_WIN-1:0]     upd_best_err;
    logic [NB_DLY-1:0]     upd_best_dly;

    // A clear discards a same-cycle strobe entirely, including the shift.
    assign accept  = i_valid & i_enable & ~i_clear;

    // taps[d] is the reference delayed by d accepted strobes; tap 0 is the
    // live reference bit.
    assign taps    = {sr_q, i_ref};
    assign sel_dly = (state_q == LOCK) ? delay_q : cand_q;
    assign err_bit = i_rx ^ taps[sel_dly];

    // Window total including the current strobe's error.
    assign total   = win_acc_q + NB_WIN'(err_bit);
    assign win_end = (win_cnt_q == LAST_WIN);

    // Best-so-far including the window that is closing now. The comparison
    // is strict, so on a tie the lower delay is kept.
    assign better       = (total < best_err_q);
    assign upd_best_err = better ? total  : best_err_q;
    assign upd_best_dly = better ? cand_q : best_dly_q;

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cand_d     = cand_q;
        win_acc_d  = win_acc_q;
        win_cnt_d  = win_cnt_q;
        best_err_d = best_err_q;
        best_dly_d = best_dly_q;
        delay_d    = delay_q;
        min_err_d  = min_err_q;
        bit_cnt_d  = bit_cnt_q;
        err_cnt_d  = err_cnt_q;
        lol_d      = 1'b0;

        if (i_clear) begin
            // The delay line and the last search result are deliberately
            // kept.
            state_d    = SEARCH;
            cand_d     = '0;
            win_acc_d  = '0;
            win_cnt_d  = '0;
            best_err_d = '1;
            bit_cnt_d  = '0;
            err_cnt_d  = '0;
        end else if (accept) begin
            sr_d      = taps[NDELAY-2:0];
            win_acc_d = total;
            win_cnt_d = win_cnt_q + NB_WIN'(1);

            case (state_q)
                SEARCH: begin
                    if (win_end) begin
                        win_acc_d = '0;
                        win_cnt_d = '0;
                        if (total == '0) begin
                            // Error-free window: no later candidate can
                            // beat it, so lock at once.
                            delay_d   = cand_q;
                            min_err_d = '0;
                            state_d   = LOCK;
                        end else begin
                            best_err_d = upd_best_err;
                            best_dly_d = upd_best_dly;
                            if (cand_q == LAST_CAND) begin
                                delay_d   = upd_best_dly;
                                min_err_d = upd_best_err;
                                state_d   = LOCK;
                            end else begin
                                cand_d = cand_q + NB_DLY'(1);
                            end
                        end
                    end
                end

                LOCK: begin
                    if (!cnt_full(bit_cnt_q)) begin
                        bit_cnt_d = cnt_step(bit_cnt_q, 1'b1);
                        err_cnt_d = cnt_step(err_cnt_q, err_bit);
                    end
                    if (win_end) begin
                        win_acc_d = '0;
                        win_cnt_d = '0;
                        if ({1'b0, total} > LOL_LIM) begin
                            // The cumulative counters survive a re-search.
                            lol_d      = 1'b1;
                            state_d    = SEARCH;
                            cand_d     = '0;
                            best_err_d = '1;
                        end
                    end
                end

                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= SEARCH;
            sr_q       <= '0;
            cand_q     <= '0;
            win_acc_q  <= '0;
            win_cnt_q  <= '0;
            best_err_q <= '1;
            best_dly_q <= '0;
            delay_q    <= '0;
            min_err_q  <= '1;
            bit_cnt_q  <= '0;
            err_cnt_q  <= '0;
            lol_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cand_q     <= cand_d;
            win_acc_q  <= win_acc_d;
            win_cnt_q  <= win_cnt_d;
            best_err_q <= best_err_d;
            best_dly_q <= best_dly_d;
            delay_q    <= delay_d;
            min_err_q  <= min_err_d;
            bit_cnt_q  <= bit_cnt_d;
            err_cnt_q  <= err_cnt_d;
            lol_q      <= lol_d;
        end
    end

    assign o_locked    = (state_q == LOCK);
    assign o_delay     = delay_q;
    assign o_min_err   = min_err_q;
    assign o_bit_count = bit_cnt_q;
    assign o_err_count = err_cnt_q;
    assign o_lol       = lol_q;

endmodule

// File: tb/tb_ber_meter.sv
// ----------------------------------------------------------------------------
// tb_ber_meter
//
// Directed bench for ber_meter with small parameters (8 delays, 15-strobe
// windows, 8-bit counters).
//
// The reference is a period-8 pattern (8'h17, LSB first). Its XOR with any
// rotation by 1..7 has at least 4 ones per period, so a 15-strobe window at a
// wrong delay always holds at least 4 errors (at least 3 with one injected
// flip). The correct delay therefore wins unambiguously.
// ----------------------------------------------------------------------------
module tb_ber_meter;

    localparam int NDELAY     = 8;
    localparam int NB_DLY     = 3;
    localparam int WINDOW     = 15;
    localparam int NB_WIN     = 4;
    localparam int LOL_THRESH = 3;
    localparam int NB_COUNT   = 8;

    logic                clk = 1'b0;
    logic                i_reset = 1'b0;
    logic                i_enable = 1'b0;
    logic                i_valid = 1'b0;
    logic                i_ref = 1'b0;
    logic                i_rx = 1'b0;
    logic                i_clear = 1'b0;
    logic                o_locked;
    logic [NB_DLY-1:0]   o_delay;
    logic [NB_WIN-1:0]   o_min_err;
    logic [NB_COUNT-1:0] o_bit_count;
    logic [NB_COUNT-1:0] o_err_count;
    logic                o_lol;

    ber_meter #(
        .NDELAY    (NDELAY),
        .NB_DLY    (NB_DLY),
        .WINDOW    (WINDOW),
        .NB_WIN    (NB_WIN),
        .LOL_THRESH(LOL_THRESH),
        .NB_COUNT  (NB_COUNT)
    ) dut (
        .clock      (clk),
        .i_reset    (i_reset),
        .i_enable   (i_enable),
        .i_valid    (i_valid),
        .i_ref      (i_ref),
        .i_rx       (i_rx),
        .i_clear    (i_clear),
        .o_locked   (o_locked),
        .o_delay    (o_delay),
        .o_min_err  (o_min_err),
        .o_bit_count(o_bit_count),
        .o_err_count(o_err_count),
        .o_lol      (o_lol)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] pat   = 8'h17;
    bit         h[8];          // h[i] = reference i+1 accepted strobes ago
    int         g     = 0;     // global accepted-strobe index
    int         nclr  = 0;     // accepted strobes since the last clear
    int         trk   = -1;    // delay used to count expected errors (-1 = off)
    int         errs  = 0;

    typedef struct {
        int          dly;
        bit          flips;
        int          gap;
        logic [2:0]  exp_dly;
        logic [3:0]  exp_min;
        int          n_lock;
        int          exp_err;
    } vec_t;

    vec_t vecs[5];

    function automatic bit tap(input int d, input bit r);
        return (d == 0) ? r : h[d-1];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One accepted strobe with the channel at delay dly, then gap idle cycles.
    task automatic strobe(input int dly, input bit flip, input int gap);
        bit r;
        bit x;
        @(negedge clk);
        r = pat[g % 8];
        x = tap(dly, r) ^ flip;
        if (trk >= 0 && x != tap(trk, r)) errs++;
        i_ref    = r;
        i_rx     = x;
        i_enable = 1'b1;
        i_valid  = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        for (int i = 7; i > 0; i--) h[i] = h[i-1];
        h[0] = r;
        g++;
        nclr++;
        for (int k = 0; k < gap; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        i_clear = 1'b1;
        @(posedge clk);
        #1;
        i_clear = 1'b0;
        nclr = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) h[i] = 1'b0;

        vecs[0] = '{3, 1'b0, 1, 3'd3, 4'd0,  60, 0};
        vecs[1] = '{0, 1'b0, 3, 3'd0, 4'd0,  15, 0};
        vecs[2] = '{7, 1'b0, 0, 3'd7, 4'd0, 120, 0};
        vecs[3] = '{5, 1'b1, 0, 3'd5, 4'd1, 120, 2};
        vecs[4] = '{2, 1'b1, 2, 3'd2, 4'd1, 120, 2};

        // Asynchronous reset, checked before the first clock edge.
        #1 i_reset = 1'b1;
        #1;
        chk("rst_locked",  64'(o_locked),    64'd0);
        chk("rst_delay",   64'(o_delay),     64'd0);
        chk("rst_min_err", 64'(o_min_err),   64'h0F);
        chk("rst_bits",    64'(o_bit_count), 64'd0);
        chk("rst_errs",    64'(o_err_count), 64'd0);
        chk("rst_lol",     64'(o_lol),       64'd0);
        @(negedge clk);
        @(negedge clk);
        i_reset = 1'b0;

        // Fill the delay line with real pattern history.
        for (int k = 0; k < 20; k++) strobe(0, 1'b0, 0);

        for (int v = 0; v < 5; v++) begin
            logic [2:0] prev_dly;
            prev_dly = o_delay;
            do_clear();
            chk($sformatf("v%0d_clr_locked", v), 64'(o_locked),    64'd0);
            chk($sformatf("v%0d_clr_bits", v),   64'(o_bit_count), 64'd0);
            chk($sformatf("v%0d_clr_hold", v),   64'(o_delay),     64'(prev_dly));
            for (int k = 0; k < vecs[v].n_lock - 1; k++)
                strobe(vecs[v].dly, vecs[v].flips && (nclr % 15 == 7), vecs[v].gap);
            chk($sformatf("v%0d_prelock", v), 64'(o_locked), 64'd0);
            strobe(vecs[v].dly, vecs[v].flips && (nclr % 15 == 7), 0);
            chk($sformatf("v%0d_locked", v),  64'(o_locked),    64'd1);
            chk($sformatf("v%0d_delay", v),   64'(o_delay),     64'(vecs[v].exp_dly));
            chk($sformatf("v%0d_min_err", v), 64'(o_min_err),   64'(vecs[v].exp_min));
            chk($sformatf("v%0d_bits0", v),   64'(o_bit_count), 64'd0);
            for (int k = 0; k < 30; k++)
                strobe(vecs[v].dly, vecs[v].flips && (nclr % 15 == 7), vecs[v].gap);
            chk($sformatf("v%0d_bits30", v),  64'(o_bit_count), 64'd30);
            chk($sformatf("v%0d_errs", v),    64'(o_err_count), 64'(vecs[v].exp_err));
            chk($sformatf("v%0d_still", v),   64'(o_locked),    64'd1);
            chk($sformatf("v%0d_lol", v),     64'(o_lol),       64'd0);
        end

        // Loss of lock: lock at 3, then the channel moves to 6.
        do_clear();
        for (int k = 0; k < 60; k++) strobe(3, 1'b0, 1);
        chk("lol_pre_locked", 64'(o_locked), 64'd1);
        trk  = 3;
        errs = 0;
        for (int k = 0; k < 14; k++) strobe(6, 1'b0, 0);
        chk("lol_not_yet",    64'(o_lol),       64'd0);
        chk("lol_hold_lock",  64'(o_locked),    64'd1);
        strobe(6, 1'b0, 0);
        chk("lol_pulse",      64'(o_lol),       64'd1);
        chk("lol_unlocked",   64'(o_locked),    64'd0);
        chk("lol_bits",       64'(o_bit_count), 64'd15);
        chk("lol_errs",       64'(o_err_count), 64'(errs));
        @(posedge clk);
        #1;
        chk("lol_one_cycle",  64'(o_lol),       64'd0);
        trk = -1;
        for (int k = 0; k < 104; k++) strobe(6, 1'b0, 0);
        chk("relock_early",   64'(o_locked),    64'd0);
        chk("relock_bits_kept", 64'(o_bit_count), 64'd15);
        strobe(6, 1'b0, 0);
        chk("relock_locked",  64'(o_locked),    64'd1);
        chk("relock_delay",   64'(o_delay),     64'd6);
        chk("relock_min_err", 64'(o_min_err),   64'd0);
        chk("relock_bits",    64'(o_bit_count), 64'd15);
        chk("relock_errs",    64'(o_err_count), 64'(errs));

        // Clear in the same cycle as a strobe while locked.
        @(negedge clk);
        i_ref    = pat[g % 8];
        i_rx     = ~i_ref;
        i_valid  = 1'b1;
        i_clear  = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_clear = 1'b0;
        nclr    = 0;
        chk("clrs_locked",  64'(o_locked),    64'd0);
        chk("clrs_bits",    64'(o_bit_count), 64'd0);
        chk("clrs_errs",    64'(o_err_count), 64'd0);
        chk("clrs_delay",   64'(o_delay),     64'd6);
        chk("clrs_min_err", 64'(o_min_err),   64'd0);
        for (int k = 0; k < 44; k++) strobe(2, 1'b0, 3);
        chk("clrs_prelock", 64'(o_locked), 64'd0);
        strobe(2, 1'b0, 0);
        chk("clrs_locked2", 64'(o_locked), 64'd1);
        chk("clrs_delay2",  64'(o_delay),  64'd2);

        // Enable low: valid strobes are ignored, delay line included.
        for (int k = 0; k < 3; k++) strobe(2, 1'b0, 0);
        chk("en_bits3", 64'(o_bit_count), 64'd3);
        @(negedge clk);
        i_enable = 1'b0;
        i_valid  = 1'b1;
        i_ref    = 1'b1;
        i_rx     = 1'b0;
        for (int k = 0; k < 5; k++) @(posedge clk);
        #1;
        chk("en_off_bits",   64'(o_bit_count), 64'd3);
        chk("en_off_locked", 64'(o_locked),    64'd1);
        i_valid = 1'b0;
        strobe(2, 1'b0, 0);
        chk("en_on_bits", 64'(o_bit_count), 64'd4);
        chk("en_on_errs", 64'(o_err_count), 64'd0);

        // Counter saturation at 8 bits.
        do_clear();
        for (int k = 0; k < 15; k++) strobe(0, 1'b0, 0);
        chk("sat_locked", 64'(o_locked), 64'd1);
        chk("sat_delay",  64'(o_delay),  64'd0);
        for (int k = 0; k < 250; k++) strobe(0, k == 100, 0);
        chk("sat_bits250", 64'(o_bit_count), 64'd250);
        chk("sat_errs1",   64'(o_err_count), 64'd1);
        for (int k = 250; k < 260; k++) strobe(0, k == 257, 0);
        chk("sat_bits255", 64'(o_bit_count), 64'hFF);
        chk("sat_errs_frozen", 64'(o_err_count), 64'd1);
        chk("sat_still_locked", 64'(o_locked), 64'd1);

        // Asynchronous reset mid-operation, between clock edges.
        @(posedge clk);
        #2 i_reset = 1'b1;
        #1;
        chk("arst_bits",    64'(o_bit_count), 64'd0);
        chk("arst_errs",    64'(o_err_count), 64'd0);
        chk("arst_locked",  64'(o_locked),    64'd0);
        chk("arst_min_err", 64'(o_min_err),   64'h0F);
        @(negedge clk);
        i_reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ber_meter.md
# ber_meter

Parametrised bit-error-rate meter for the PRBS transmit/receive chain. It compares the sliced receive bit stream against the local PRBS reference and sweeps a programmable range of reference delays to find the alignment with the fewest errors. It then locks to that alignment, keeps cumulative saturating bit and error counts, and re-searches automatically on loss of lock. It sits after the phase-select/slicer stage and replaces the fixed-depth minimum-error BER block.

## Interface
- NDELAY, 512, number of candidate delays searched (taps 0..NDELAY-1)
- NB_DLY, 9, width of delay index; must equal clog2(NDELAY)
- WINDOW, 511, strobes accumulated per candidate / per lock-check window
- NB_WIN, 9, width of window error accumulator; must be at least clog2(WINDOW+1)
- LOL_THRESH, 127, window error count above which lock is declared lost
- NB_COUNT, 64, width of cumulative bit/error counters
- clock  in  1  system clock
- i_reset  in  1  reset; asynchronous and active-high
- i_enable  in  1  global enable; when low, no state changes except reset and clear
- i_valid  in  1  symbol strobe; a strobe is accepted when i_valid & i_enable
- i_ref  in  1  PRBS reference bit
- i_rx  in  1  sliced receive bit
- i_clear  in  1  synchronous restart of search and counters
- o_locked  out  1  high in LOCK state
- o_delay  out  NB_DLY  selected delay (best candidate)
- o_min_err  out  NB_WIN  error count of best window in last search
- o_bit_count  out  NB_COUNT  bits counted while locked
- o_err_count  out  NB_COUNT  errors counted while locked
- o_lol  out  1  one-cycle pulse on loss of lock

## Operation
- Delay line: NDELAY-1 bit shift register sr, shifted on every accepted strobe (sr[0]<=i_ref). tap(d) = i_ref when d=0, sr[d-1] otherwise. err = i_rx XOR tap(d).
- The shift register is never cleared by i_clear; reset clears it to 0.
- States: SEARCH, LOCK.
- SEARCH: candidate cand starts at 0. Each accepted strobe adds err(cand) to win_acc and increments win_cnt. On the WINDOW-th strobe, the total includes that strobe's error:
  - if total == 0: o_delay<=cand, o_min_err<=0, go LOCK (early lock).
  - else if total < best_err (strict): best_err<=total, best_dly<=cand. Ties keep the lower delay.
  - then clear win_acc/win_cnt. If cand == NDELAY-1: o_delay<=best_dly, o_min_err<=best_err, go LOCK; else cand++.
- LOCK: each accepted strobe updates the counters: o_bit_count++, o_err_count += err(o_delay). Both counters freeze once o_bit_count reaches all-ones. The window accumulator also runs. At the end of each window:
  - if total > LOL_THRESH: o_lol pulses, go SEARCH with cand=0 and best_err=all-ones. Cumulative counters are kept.
  - otherwise clear the window and stay in LOCK.
- Counters do not change during SEARCH.
- i_clear: overrides a same-cycle strobe. Forces SEARCH, cand=0, win_acc=win_cnt=0, best_err=all-ones, o_bit_count=o_err_count=0, o_locked=0. o_delay and o_min_err hold.
- i_enable low: strobes are ignored; all state holds.

## Timing
- Reset values: o_locked=0, o_delay=0, o_min_err=all-ones, o_bit_count=0, o_err_count=0, o_lol=0. State is SEARCH, cand=0, sr=0.
- All outputs are registered. Counters and o_locked update on the clock edge that samples the strobe, so they are visible one cycle after the strobe.
- o_lol is high for exactly the one cycle in which o_locked falls.
- Worst-case lock time: NDELAY*WINDOW accepted strobes. With early lock, it is (d+1)*WINDOW strobes for true delay d.
- Strobes may arrive on consecutive cycles or sparsely; behaviour depends only on accepted strobes.
- Async reset mid-operation returns to reset values immediately; the first strobe after release starts candidate 0.

## Test plan
- Reset: assert i_reset asynchronously, with no clock edge needed -> o_locked=0, o_delay=0, o_min_err=9'h1FF, counts=0, o_lol=0.
- i_rx = i_ref delayed 37 strobes, error-free, strobe every 4 cycles -> lock after 38*511 strobes, o_delay=37, o_min_err=0, o_err_count stays 0, o_bit_count increments per strobe.
- Delay 5 with every 64th rx bit flipped -> full 512-window sweep, then o_delay=5, o_min_err=7 or 8. o_err_count/o_bit_count is approximately 1/64.
- Locked at delay 37, then switch the channel to delay 100 -> o_lol one-cycle pulse within 511 strobes, re-lock with o_delay=100. Counters are not reset across the re-search.
- i_clear asserted in the same cycle as a strobe, mid-LOCK -> next cycle o_locked=0, counts=0, cand=0. The strobe is not counted.
- NB_COUNT=8, error-free locked stream -> o_bit_count stops at 255 and o_err_count freezes. Async reset then clears both.
